// File: rtl/mem_sequencer_if.sv
// CPU-side and SRAM-side signals of the memory sequencer, bundled as one port.
// master = the sequencer, slave = the CPU core plus SRAM pins it serves.
interface mem_sequencer_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_ctrl_signal;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic [19:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [3:0]  ram_be_n;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic [2:0]  dbg_state;

    modport master (
        input  if_req, if_addr, mem_addr, mem_wdata, mem_ctrl_signal, ram_rdata,
        output if_rdata, mem_rdata, mem_stall,
        output ram_addr, ram_wdata, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n,
        output dbg_state
    );

    modport slave (
        output if_req, if_addr, mem_addr, mem_wdata, mem_ctrl_signal, ram_rdata,
        input  if_rdata, mem_rdata, mem_stall,
        input  ram_addr, ram_wdata, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n,
        input  dbg_state
    );
endinterface

// File: rtl/mem_sequencer.sv
// Serialises one data access and one instruction fetch per pipeline step onto a
// single-port SRAM, with byte-lane steering for stores and extension for loads.
module mem_sequencer #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk_50M,
    input  logic            reset_btn,
    mem_sequencer_if.master bus
);

    // Flow control: the CPU holds every request input stable while mem_stall is
    // high; results are valid in the single cycle where mem_stall drops (DONE).
    localparam int CW = (WAIT_CYCLES < 4) ? 2 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DATA_RD = 3'd1,
        DATA_WR = 3'd2,
        WR_HOLD = 3'd3,
        INST_RD = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          data_req;
    logic          is_store;
    logic          last;
    logic          cap_data;
    logic          cap_inst;

    logic [3:0]    lane_be_n;
    logic [31:0]   lane_wdata;

    logic          ce_next, oe_next, we_next;
    logic [3:0]    be_next;
    logic [19:0]   addr_next;
    logic [31:0]   wdata_next;

    assign data_req = bus.mem_ctrl_signal[4] | bus.mem_ctrl_signal[3];
    assign is_store = bus.mem_ctrl_signal[3];
    assign last     = (cnt == CNT_LAST);
    assign cap_data = (state == DATA_RD) && last;
    assign cap_inst = (state == INST_RD) && last;

    assign bus.mem_stall = !reset_btn && (state != DONE) && (data_req || bus.if_req);
    assign bus.dbg_state = state;

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    always_comb begin
        lane_be_n  = 4'b0000;
        lane_wdata = bus.mem_wdata;
        case (bus.mem_ctrl_signal[1:0])
            2'b00: begin
                lane_be_n  = ~(4'b0001 << bus.mem_addr[1:0]);
                lane_wdata = {4{bus.mem_wdata[7:0]}};
            end
            2'b01: begin
                lane_be_n  = ~(4'b0011 << {bus.mem_addr[1], 1'b0});
                lane_wdata = {2{bus.mem_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (data_req)
                    state_next = is_store ? DATA_WR : DATA_RD;
                else if (bus.if_req)
                    state_next = INST_RD;
            end
            DATA_RD: begin
                if (last) begin
                    cnt_next   = '0;
                    state_next = bus.if_req ? INST_RD : DONE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DATA_WR: begin
                if (last) begin
                    cnt_next   = '0;
                    state_next = WR_HOLD;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            WR_HOLD: state_next = bus.if_req ? INST_RD : DONE;
            INST_RD: begin
                if (last) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // SRAM pins are registered from the state being entered, so they line up
    // with that state's first cycle.
    always_comb begin
        ce_next    = 1'b1;
        oe_next    = 1'b1;
        we_next    = 1'b1;
        be_next    = 4'b1111;
        addr_next  = bus.ram_addr;
        wdata_next = bus.ram_wdata;
        case (state_next)
            DATA_RD: begin
                ce_next   = 1'b0;
                oe_next   = 1'b0;
                be_next   = 4'b0000;
                addr_next = bus.mem_addr[21:2];
            end
            DATA_WR: begin
                ce_next    = 1'b0;
                we_next    = 1'b0;
                be_next    = lane_be_n;
                addr_next  = bus.mem_addr[21:2];
                wdata_next = lane_wdata;
            end
            WR_HOLD: begin
                ce_next = 1'b0;
                be_next = bus.ram_be_n;
            end
            INST_RD: begin
                ce_next   = 1'b0;
                oe_next   = 1'b0;
                be_next   = 4'b0000;
                addr_next = bus.if_addr[21:2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.ram_ce_n  <= 1'b1;
            bus.ram_oe_n  <= 1'b1;
            bus.ram_we_n  <= 1'b1;
            bus.ram_be_n  <= 4'b1111;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.mem_rdata <= '0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            bus.ram_ce_n  <= ce_next;
            bus.ram_oe_n  <= oe_next;
            bus.ram_we_n  <= we_next;
            bus.ram_be_n  <= be_next;
            bus.ram_addr  <= addr_next;
            bus.ram_wdata <= wdata_next;
            if (cap_data)
                bus.mem_rdata <= extend_load(bus.ram_rdata, bus.mem_addr[1:0],
                                             bus.mem_ctrl_signal[1:0],
                                             bus.mem_ctrl_signal[2]);
            if (cap_inst)
                bus.if_rdata <= bus.ram_rdata;
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: directed scenarios plus random transactions checked
// against a transaction-level model of stall length, load results and memory.
module tb_mem_sequencer;
    localparam int W   = 1;
    localparam int BND = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_sequencer_if ifc ();
    mem_sequencer_if ifc0 ();

    mem_sequencer #(.WAIT_CYCLES(W)) dut (.clk_50M(clk), .reset_btn(rst), .bus(ifc.master));
    mem_sequencer #(.WAIT_CYCLES(0)) dut0 (.clk_50M(clk), .reset_btn(rst), .bus(ifc0.master));

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] fill(input int i);
        return (i * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    // SRAM model: asynchronous read, byte-lane writes while ce_n and we_n are low
    logic [31:0] sram [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        init_done = 1'b0;
    logic        pre_en = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    assign ifc.ram_rdata  = (!ifc.ram_ce_n && !ifc.ram_oe_n) ? sram[ifc.ram_addr[9:0]] : 32'h0BAD0BAD;
    assign ifc0.ram_rdata = (!ifc0.ram_ce_n && !ifc0.ram_oe_n) ? fill(int'(ifc0.ram_addr[9:0])) : 32'h0BAD0BAD;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) sram[i] <= fill(i);
            init_done <= 1'b1;
        end else if (pre_en) begin
            sram[pre_addr] <= pre_data;
        end else if (!ifc.ram_ce_n && !ifc.ram_we_n) begin
            for (int b = 0; b < 4; b++)
                if (!ifc.ram_be_n[b]) sram[ifc.ram_addr[9:0]][8*b +: 8] <= ifc.ram_wdata[8*b +: 8];
        end
    end

    logic [19:0] tr_addr [0:BND-1];
    logic        tr_ce [0:BND-1];
    logic        tr_oe [0:BND-1];
    logic        tr_we [0:BND-1];
    logic [3:0]  tr_be [0:BND-1];
    logic [31:0] tr_wd [0:BND-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ifr, input logic [31:0] ia, input logic [4:0] ctrl,
                         input logic [31:0] ma, input logic [31:0] wd);
        ifc.if_req          = ifr;
        ifc.if_addr         = ia;
        ifc.mem_ctrl_signal = ctrl;
        ifc.mem_addr        = ma;
        ifc.mem_wdata       = wd;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a[9:0]; pre_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied; counts stall cycles
    // and records the SRAM pins of each one. Returns in the first non-stall cycle.
    task automatic run_txn(output int stalls);
        stalls = 0;
        #1;
        while (ifc.mem_stall === 1'b1 && stalls < BND) begin
            tr_addr[stalls] = ifc.ram_addr;
            tr_ce[stalls]   = ifc.ram_ce_n;
            tr_oe[stalls]   = ifc.ram_oe_n;
            tr_we[stalls]   = ifc.ram_we_n;
            tr_be[stalls]   = ifc.ram_be_n;
            tr_wd[stalls]   = ifc.ram_wdata;
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls >= BND) begin
            n_cmp++; n_bad++;
            $error("FAIL stall_bound: observed=%0d cycles expected=<%0d", stalls, BND);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [4:0] ctrl);
        logic [31:0] v;
        int off;
        off = int'(a[1:0]);
        if (ctrl[1:0] == 2'b00) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (ctrl[2] && v >= 128) v = v | 32'hFFFFFF00;
        end else if (ctrl[1:0] == 2'b01) begin
            v = (word >> (16 * (off / 2))) & 32'hFFFF;
            if (ctrl[2] && v >= 32768) v = v | 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] a,
                                              input logic [31:0] wd, input logic [1:0] size);
        int sh;
        if (size == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end else if (size == 2'b01) begin
            sh = 16 * int'(a[1]);
            return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s, exp_s, strobes, widx, iidx, r;
        logic [4:0]  ctrl;
        logic [31:0] ma, ia, wd, last_if, exp_if;
        logic        ifr, ld, st;

        for (int i = 0; i < 1024; i++) ref_mem[i] = fill(i);
        rst = 1'b1;
        drive(1'b0, 32'h0, 5'b0, 32'h0, 32'h0);
        ifc0.if_req = 1'b0; ifc0.if_addr = '0; ifc0.mem_ctrl_signal = '0;
        ifc0.mem_addr = '0; ifc0.mem_wdata = '0;
        repeat (3) @(negedge clk);

        // reset state, with a request present to confirm stall stays low
        ifc.if_req = 1'b1;
        #1;
        check("rst_ce_n", ifc.ram_ce_n, 1'b1);
        check("rst_oe_n", ifc.ram_oe_n, 1'b1);
        check("rst_we_n", ifc.ram_we_n, 1'b1);
        check("rst_be_n", ifc.ram_be_n, 4'hF);
        check("rst_addr", ifc.ram_addr, 20'h0);
        check("rst_wdata", ifc.ram_wdata, 32'h0);
        check("rst_if_rdata", ifc.if_rdata, 32'h0);
        check("rst_mem_rdata", ifc.mem_rdata, 32'h0);
        check("rst_stall", ifc.mem_stall, 1'b0);
        check("rst_state", ifc.dbg_state, 3'd0);
        ifc.if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // no request: SRAM idle and no stall
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("idle_stall", ifc.mem_stall, 1'b0);
            check("idle_ce_n", ifc.ram_ce_n, 1'b1);
        end

        // fetch only
        preload(1, 32'h3C011234);
        @(negedge clk);
        drive(1'b1, 32'h80000004, 5'b0, 32'h0, 32'h0);
        run_txn(s);
        check("fetch_stalls", s, 3);
        for (int k = 1; k <= 2; k++) begin
            check("fetch_addr", tr_addr[k], 20'h00001);
            check("fetch_ce_oe", {tr_ce[k], tr_oe[k]}, 2'b00);
        end
        check("fetch_rdata", ifc.if_rdata, 32'h3C011234);
        check("fetch_done_stall", ifc.mem_stall, 1'b0);
        drive(1'b0, 32'h0, 5'b0, 32'h0, 32'h0);

        // signed then unsigned byte load
        preload(32'h40, 32'h80FF7F01);
        @(negedge clk);
        drive(1'b0, 32'h0, 5'b10100, 32'h80000103, 32'h0);
        run_txn(s);
        check("lb_stalls", s, 3);
        check("lb_signed", ifc.mem_rdata, 32'hFFFFFF80);
        drive(1'b0, 32'h0, 5'b0, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 5'b10000, 32'h80000103, 32'h0);
        run_txn(s);
        check("lbu_zero", ifc.mem_rdata, 32'h00000080);
        drive(1'b0, 32'h0, 5'b0, 32'h0, 32'h0);

        // half store then fetch
        @(negedge clk);
        drive(1'b1, 32'h80000004, 5'b01001, 32'h80000002, 32'h0000BEEF);
        run_txn(s);
        check("sh_stalls", s, 6);
        for (int k = 1; k <= 2; k++) begin
            check("sh_we_n", tr_we[k], 1'b0);
            check("sh_be_n", tr_be[k], 4'b0011);
            check("sh_wdata", tr_wd[k], 32'hBEEFBEEF);
        end
        check("sh_hold_we_ce", {tr_we[3], tr_ce[3]}, 2'b10);
        check("sh_hold_addr", tr_addr[3], 20'h00000);
        check("sh_hold_wdata", tr_wd[3], 32'hBEEFBEEF);
        check("sh_fetch_addr", tr_addr[4], 20'h00001);
        check("sh_fetch_oe", tr_oe[4], 1'b0);
        check("sh_if_rdata", ifc.if_rdata, 32'h3C011234);
        ref_mem[0] = ref_store(ref_mem[0], 32'h80000002, 32'h0000BEEF, 2'b01);
        drive(1'b0, 32'h0, 5'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("sh_mem_word", sram[0], ref_mem[0]);

        // load + fetch ordering, and no re-service of a held request
        preload(2, 32'h11223344);
        @(negedge clk);
        drive(1'b1, 32'h80000004, 5'b10010, 32'h80000008, 32'h0);
        run_txn(s);
        check("lf_stalls", s, 5);
        check("lf_data_first", {tr_addr[1], tr_oe[1]}, {20'h00002, 1'b0});
        check("lf_inst_second", {tr_addr[3], tr_oe[3]}, {20'h00001, 1'b0});
        check("lf_mem_rdata", ifc.mem_rdata, 32'h11223344);
        check("lf_if_rdata", ifc.if_rdata, 32'h3C011234);
        @(negedge clk); #1;
        check("lf_next_state", ifc.dbg_state, 3'd0);
        check("lf_next_stall", ifc.mem_stall, 1'b1);
        check("lf_next_oe", ifc.ram_oe_n, 1'b1);
        drive(1'b0, 32'h0, 5'b0, 32'h0, 32'h0);

        // reset during the second write-strobe cycle
        @(negedge clk);
        drive(1'b0, 32'h0, 5'b01010, 32'h800007D0, 32'h12345678);
        @(negedge clk);
        @(negedge clk); #1;
        check("rw_in_write", ifc.ram_we_n, 1'b0);
        rst = 1'b1;
        @(negedge clk); #1;
        check("rw_we_ce", {ifc.ram_we_n, ifc.ram_ce_n}, 2'b11);
        check("rw_be_n", ifc.ram_be_n, 4'hF);
        check("rw_state", ifc.dbg_state, 3'd0);
        check("rw_stall", ifc.mem_stall, 1'b0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 5'b0, 32'h0, 32'h0);
        last_if = 32'h0;

        // zero wait cycles: single strobe cycle, two stall cycles
        @(negedge clk);
        ifc0.if_req = 1'b1; ifc0.if_addr = 32'h80000010;
        s = 0; strobes = 0;
        #1;
        while (ifc0.mem_stall === 1'b1 && s < BND) begin
            if (ifc0.ram_oe_n === 1'b0) strobes++;
            s++;
            @(negedge clk); #1;
        end
        check("w0_stalls", s, 2);
        check("w0_strobes", strobes, 1);
        check("w0_if_rdata", ifc0.if_rdata, fill(4));
        ifc0.if_req = 1'b0;

        // random transactions against the transaction-level model
        for (int t = 0; t < 40; t++) begin
            r    = $urandom_range(0, 3);
            ld   = (r == 1) || (r == 3);
            st   = (r >= 2);
            ifr  = $urandom_range(0, 1) == 1;
            widx = $urandom_range(16, 31);
            iidx = $urandom_range(16, 31);
            ctrl = {ld, st, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
            ma   = 32'h80000000 | (widx << 2) | $urandom_range(0, 3);
            ia   = 32'h80000000 | (iidx << 2);
            wd   = $urandom;
            exp_s = 0;
            if (ld || st || ifr)
                exp_s = 1 + (st ? W + 2 : (ld ? W + 1 : 0)) + (ifr ? W + 1 : 0);
            @(negedge clk);
            drive(ifr, ia, ctrl, ma, wd);
            run_txn(s);
            check("rnd_stalls", s, exp_s);
            if (ld && !st) check("rnd_load", ifc.mem_rdata, ref_load(ref_mem[widx], ma, ctrl));
            if (st) ref_mem[widx] = ref_store(ref_mem[widx], ma, wd, ctrl[1:0]);
            exp_if = ifr ? ref_mem[iidx] : last_if;
            check("rnd_if_rdata", ifc.if_rdata, exp_if);
            last_if = exp_if;
            drive(1'b0, 32'h0, 5'b0, 32'h0, 32'h0);
        end
        @(negedge clk);
        for (int i = 16; i < 32; i++) check("rnd_mem", sram[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
